// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the reset monitors, the CPU core and reset_sequencer.
// The master drives the requests, pc and clear; the slave (the sequencer) drives reset and status.
interface reset_sequencer_if;
    logic [3:0]  req;
    logic [15:0] pc;
    logic        cause_clr;
    logic        sys_rst;
    logic        busy;
    logic [3:0]  rst_cause;
    logic [7:0]  rst_cnt;

    modport master (
        output req, pc, cause_clr,
        input  sys_rst, busy, rst_cause, rst_cnt
    );

    modport slave (
        input  req, pc, cause_clr,
        output sys_rst, busy, rst_cause, rst_cnt
    );
endinterface

// File: rtl/reset_sequencer.sv
// Holds the CPU in reset for RST_HOLD cycles after the last request, then waits for the reset-vector fetch.
// Optional cause/episode logging is enabled with macro VRASED_RESET_CAUSE_LOG_EN.
module reset_sequencer #(
    parameter int unsigned RST_HOLD      = 16,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
    input  logic             clk,
    input  logic             reset_n,
    reset_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ASSERT = 2'b01,
        BOOT   = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_RELOAD = 8'(RST_HOLD - 1);

    state_t     r_state;
    logic [7:0] r_hold;
    logic       r_sys_rst;
    logic       r_busy;

    logic w_any_req;
    logic w_pc_hit;

    assign w_any_req = |bus.req;
    assign w_pc_hit  = (bus.pc == RESET_HANDLER);

    // Outputs are registered alongside the state so nothing combinational reaches them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ASSERT;
            r_hold    <= HOLD_RELOAD;
            r_sys_rst <= 1'b1;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state   <= ASSERT;
                        r_hold    <= HOLD_RELOAD;
                        r_sys_rst <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_sys_rst <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                ASSERT: begin
                    r_sys_rst <= 1'b1;
                    r_busy    <= 1'b1;
                    if (w_any_req) begin
                        r_hold <= HOLD_RELOAD;
                    end else if (r_hold == '0) begin
                        r_state   <= BOOT;
                        r_sys_rst <= 1'b0;
                    end else begin
                        r_hold <= r_hold - 8'd1;
                    end
                end
                BOOT: begin
                    // A fresh request outranks the reset-vector fetch in the same cycle.
                    if (w_any_req) begin
                        r_state   <= ASSERT;
                        r_hold    <= HOLD_RELOAD;
                        r_sys_rst <= 1'b1;
                        r_busy    <= 1'b1;
                    end else if (w_pc_hit) begin
                        r_state   <= IDLE;
                        r_sys_rst <= 1'b0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_sys_rst <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ASSERT;
                    r_hold    <= HOLD_RELOAD;
                    r_sys_rst <= 1'b1;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sys_rst = r_sys_rst;
    assign bus.busy    = r_busy;

`ifdef VRASED_RESET_CAUSE_LOG_EN
    logic [3:0] r_rst_cause;
    logic [7:0] r_rst_cnt;
    logic       w_clr;
    logic       w_episode_start;

    assign w_clr           = bus.cause_clr && (r_state == IDLE);
    assign w_episode_start = w_any_req && ((r_state == IDLE) || (r_state == BOOT));

    // Clear is applied before the OR-in, so a coincident request survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_cause <= '0;
            r_rst_cnt   <= '0;
        end else begin
            r_rst_cause <= (w_clr ? 4'b0000 : r_rst_cause) | bus.req;
            if (w_episode_start) begin
                if (w_clr) begin
                    r_rst_cnt <= 8'd1;
                end else if (r_rst_cnt != 8'hFF) begin
                    r_rst_cnt <= r_rst_cnt + 8'd1;
                end
            end else if (w_clr) begin
                r_rst_cnt <= '0;
            end
        end
    end

    assign bus.rst_cause = r_rst_cause;
    assign bus.rst_cnt   = r_rst_cnt;
`else
    assign bus.rst_cause = '0;
    assign bus.rst_cnt   = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random traffic against a timestamp model.
module tb_reset_sequencer;

    localparam int unsigned H       = 16;
    localparam logic [15:0] HANDLER = 16'hFFFE;
`ifdef VRASED_RESET_CAUSE_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;

    reset_sequencer_if bus ();

    reset_sequencer #(
        .RST_HOLD      (H),
        .RESET_HANDLER (HANDLER)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: an episode is live from its first request until the pc hits the
    // handler; reset is driven while fewer than H edges have passed since the last request.
    int unsigned edge_no  = 0;
    int unsigned last_req = 0;
    bit          m_busy;
    bit          m_boot;
    logic [3:0]  m_cause;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic bump_cnt();
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic model_edge();
        bit any;
        edge_no++;
        any = |bus.req;
        if (!m_busy) begin
            if (bus.cause_clr) begin
                m_cause = '0;
                m_cnt   = 0;
            end
            if (any) begin
                m_busy   = 1'b1;
                m_boot   = 1'b0;
                last_req = edge_no;
                bump_cnt();
            end
        end else if (!m_boot) begin
            if (any) last_req = edge_no;
            else if (edge_no - last_req >= H) m_boot = 1'b1;
        end else begin
            if (any) begin
                m_boot   = 1'b0;
                last_req = edge_no;
                bump_cnt();
            end else if (bus.pc == HANDLER) begin
                m_busy = 1'b0;
            end
        end
        m_cause = m_cause | bus.req;
    endtask

    task automatic check_all();
        check("sys_rst",   32'(bus.sys_rst),   32'(m_busy && !m_boot));
        check("busy",      32'(bus.busy),      32'(m_busy));
        check("rst_cause", 32'(bus.rst_cause), LOG_EN ? 32'(m_cause) : 32'd0);
        check("rst_cnt",   32'(bus.rst_cnt),   LOG_EN ? 32'(m_cnt)   : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_count(input int unsigned n, inout int unsigned highs);
        repeat (n) begin
            step();
            if (bus.sys_rst) highs++;
        end
    endtask

    // Called at a negedge; reset is asserted asynchronously and checked straight away.
    task automatic apply_reset(input int unsigned cycles);
        reset_n = 1'b0;
        m_busy  = 1'b1;
        m_boot  = 1'b0;
        m_cause = '0;
        m_cnt   = 0;
        #1;
        check_all();
        repeat (cycles) begin
            @(negedge clk);
            check_all();
        end
        reset_n  = 1'b1;
        last_req = edge_no;
    endtask

    task automatic finish_boot();
        bus.req = '0;
        bus.pc  = HANDLER;
        step();
        bus.pc  = 16'h0000;
    endtask

    initial begin
        #5_000_000;
        n_errors++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int unsigned highs;
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.pc        = 16'h0000;
        bus.cause_clr = 1'b0;
        @(negedge clk);

        // Power-up hold
        apply_reset(3);
        highs = bus.sys_rst ? 1 : 0;
        run_count(20, highs);
        check("pwrup_hold", highs, H);
        check("pwrup_boot", 32'(bus.busy), 32'd1);
        finish_boot();
        check("pwrup_idle", 32'(bus.busy), 32'd0);
        check("pwrup_cnt", 32'(bus.rst_cnt), 32'd0);

        // Single one-cycle request
        highs = 0;
        bus.req = 4'b0001;
        run_count(1, highs);
        check("pulse_lat", 32'(bus.sys_rst), 32'd1);
        bus.req = '0;
        run_count(20, highs);
        check("pulse_hold", highs, H);
        check("pulse_cause", 32'(bus.rst_cause), LOG_EN ? 32'h1 : 32'h0);
        check("pulse_cnt", 32'(bus.rst_cnt), LOG_EN ? 32'd1 : 32'd0);
        finish_boot();

        // Extended, overlapping requests
        bus.cause_clr = 1'b1;
        step();
        bus.cause_clr = 1'b0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            bus.req = (i >= 10) ? 4'b1100 : 4'b0100;
            run_count(1, highs);
        end
        bus.req = '0;
        run_count(30, highs);
        check("ext_hold", highs, 40 + H - 1);
        check("ext_cause", 32'(bus.rst_cause), LOG_EN ? 32'hC : 32'h0);
        check("ext_cnt", 32'(bus.rst_cnt), LOG_EN ? 32'd1 : 32'd0);
        finish_boot();

        // Re-trigger in BOOT on the same cycle as the handler fetch
        bus.req = 4'b0001;
        step();
        bus.req = '0;
        repeat (H) step();
        check("retrig_in_boot", 32'(bus.sys_rst), 32'd0);
        bus.req = 4'b0010;
        bus.pc  = HANDLER;
        step();
        check("retrig_sysrst", 32'(bus.sys_rst), 32'd1);
        check("retrig_busy", 32'(bus.busy), 32'd1);
        check("retrig_cnt", 32'(bus.rst_cnt), LOG_EN ? 32'd3 : 32'd0);
        bus.req = '0;
        bus.pc  = 16'h0000;
        repeat (H) step();
        finish_boot();

        // Clear rules
        bus.req = 4'b1000;
        step();
        bus.req       = '0;
        bus.cause_clr = 1'b1;
        step();
        bus.cause_clr = 1'b0;
        check("clr_in_assert", 32'(bus.rst_cnt), LOG_EN ? 32'd4 : 32'd0);
        repeat (H) step();
        finish_boot();
        bus.cause_clr = 1'b1;
        step();
        check("clr_idle_cause", 32'(bus.rst_cause), 32'd0);
        check("clr_idle_cnt", 32'(bus.rst_cnt), 32'd0);
        bus.req = 4'b0001;
        step();
        bus.cause_clr = 1'b0;
        bus.req       = '0;
        check("clr_req_cause", 32'(bus.rst_cause), LOG_EN ? 32'h1 : 32'h0);
        check("clr_req_cnt", 32'(bus.rst_cnt), LOG_EN ? 32'd1 : 32'd0);
        repeat (H) step();
        finish_boot();

        // Mid-episode reset abort
        bus.req = 4'b0100;
        step();
        bus.req = '0;
        repeat (5) step();
        apply_reset(2);
        repeat (H + 2) step();
        finish_boot();

        // Saturation: back-to-back episodes re-triggered from BOOT
        for (int e = 0; e < 300; e++) begin
            bus.req = 4'b0001;
            step();
            bus.req = '0;
            repeat (H) step();
        end
        check("sat_cnt", 32'(bus.rst_cnt), LOG_EN ? 32'hFF : 32'h0);
        finish_boot();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                bus.req       = '0;
                bus.cause_clr = 1'b0;
                apply_reset($urandom_range(1, 3));
            end else begin
                bus.req       = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
                bus.pc        = ($urandom_range(0, 3) == 0) ? HANDLER : 16'($urandom);
                bus.cause_clr = ($urandom_range(0, 7) == 0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
